muldiv_sequencer: RTL and testbench

//  Iterative multiply/divide unit and HI/LO register owner for the 5-stage pipeline.

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_datapath.sv | 106 ++++++++++
 rtl/muldiv_sequencer.sv | 79 +++++++
 tb/tb_muldiv_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_t;

  localparam logic [1:0] MFHL_NONE = 2'b00;
  localparam logic [1:0] MFHL_MFLO = 2'b01;
  localparam logic [1:0] MFHL_MFHI = 2'b10;

  localparam logic [1:0] MTHL_NONE = 2'b00;
  localparam logic [1:0] MTHL_MTLO = 2'b01;
  localparam logic [1:0] MTHL_MTHI = 2'b10;

  function automatic logic opIsSigned(input muldiv_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic opIsDiv(input muldiv_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 shift-add multiplier / restoring divider sharing one 2*WIDTH accumulator.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             lastStep,
  output logic [WIDTH-1:0] hiNext,
  output logic [WIDTH-1:0] loNext
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] accum;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   rawA;
  muldiv_op_t         opLat;
  logic               negResult;
  logic               negRem;
  logic               divByZero;
  logic [CNT_W-1:0]   count;

  logic [WIDTH-1:0]   aMag;
  logic [WIDTH-1:0]   bMag;
  logic               isSigned;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divShift;
  logic [WIDTH:0]     divDiff;
  logic [2*WIDTH-1:0] accumStep;
  logic [2*WIDTH-1:0] product;

  function automatic logic [WIDTH-1:0] negIf(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] negIfWide(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  assign isSigned = opIsSigned(op);
  assign aMag     = negIf(srcA, isSigned & srcA[WIDTH-1]);
  assign bMag     = negIf(srcB, isSigned & srcB[WIDTH-1]);

  // Upper half is the running sum (mul) or partial remainder (div); lower half
  // holds the multiplier bits still to consume, or the quotient being shifted in.
  assign mulSum   = {1'b0, accum[2*WIDTH-1:WIDTH]} + {1'b0, operand};
  assign divShift = accum[2*WIDTH-1:WIDTH-1];
  assign divDiff  = divShift - {1'b0, operand};

  always_comb begin
    accumStep = accum;
    if (opIsDiv(opLat)) begin
      if (divDiff[WIDTH]) accumStep = {divShift[WIDTH-1:0], accum[WIDTH-2:0], 1'b0};
      else                accumStep = {divDiff[WIDTH-1:0], accum[WIDTH-2:0], 1'b1};
    end else begin
      if (accum[0]) accumStep = {mulSum, accum[WIDTH-1:1]};
      else          accumStep = {1'b0, accum[2*WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      accum     <= opIsDiv(op) ? {{WIDTH{1'b0}}, aMag} : {{WIDTH{1'b0}}, bMag};
      operand   <= opIsDiv(op) ? bMag : aMag;
      rawA      <= srcA;
      opLat     <= op;
      negResult <= isSigned & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
      negRem    <= isSigned & srcA[WIDTH-1];
      divByZero <= (srcB == '0);
    end else if (step) begin
      accum <= accumStep;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     count <= '0;
    else if (load)  count <= '0;
    else if (step)  count <= count + CNT_W'(1);
  end

  assign lastStep = (count == CNT_W'(WIDTH - 1));
  assign product  = negIfWide(accum, negResult);

  // Sign fix-up on magnitudes; divide by zero bypasses it and reports the raw dividend.
  always_comb begin
    hiNext = product[2*WIDTH-1:WIDTH];
    loNext = product[WIDTH-1:0];
    if (opIsDiv(opLat)) begin
      if (divByZero) begin
        hiNext = rawA;
        loNext = '1;
      end else begin
        hiNext = negIf(accum[2*WIDTH-1:WIDTH], negRem);
        loNext = negIf(accum[WIDTH-1:0], negResult);
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Mul/div control FSM, architectural HI/LO owner and decode-stage stall generator.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multordivE,
  input  logic             flushE,
  input  logic [1:0]       muldivopE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic [1:0]       mfhlD,
  input  logic             muldivD,
  input  logic [1:0]       mthlW,
  input  logic [WIDTH-1:0] wdW,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stallD
);

  md_state_t        state;
  md_state_t        stateNext;
  logic             start;
  logic             lastStep;
  logic             hiloUserD;
  logic [WIDTH-1:0] hiNext;
  logic [WIDTH-1:0] loNext;

  assign start     = multordivE & ~flushE & (state == IDLE);
  assign busy      = (state != IDLE);
  assign hiloUserD = (mfhlD != MFHL_NONE) | muldivD;
  assign stallD    = (busy | start) & hiloUserD;

  muldiv_datapath #(.WIDTH(WIDTH)) uDatapath (
    .clk      (clk),
    .reset    (reset),
    .load     (start),
    .step     (state == RUN),
    .op       (muldiv_op_t'(muldivopE)),
    .srcA     (srcaE),
    .srcB     (srcbE),
    .lastStep (lastStep),
    .hiNext   (hiNext),
    .loNext   (loNext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = RUN;
      RUN:     if (lastStep) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // MT writes only land while idle; a pending result always wins at FIX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIX) begin
      hi <= hiNext;
      lo <= loNext;
    end else if (state == IDLE) begin
      if (mthlW == MTHL_MTHI) hi <= wdW;
      if (mthlW == MTHL_MTLO) lo <= wdW;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops queued with hand-computed results.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    int               cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             multordivE;
  logic             flushE;
  logic [1:0]       muldivopE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic [1:0]       mfhlD;
  logic             muldivD;
  logic [1:0]       mthlW;
  logic [WIDTH-1:0] wdW;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stallD;

  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  logic busyPrev = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  muldiv_sequencer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .multordivE (multordivE),
    .flushE     (flushE),
    .muldivopE  (muldivopE),
    .srcaE      (srcaE),
    .srcbE      (srcbE),
    .mfhlD      (mfhlD),
    .muldivD    (muldivD),
    .mthlW      (mthlW),
    .wdW        (wdW),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .stallD     (stallD)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a falling busy outside reset marks a committed result.
  always @(negedge clk) begin
    if (reset && busyPrev && !busy) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_hi", hi, e.hi);
        check("result_lo", lo, e.lo);
        check("commit_cycle", cyc, e.cyc);
      end
    end
    busyPrev = busy;
  end

  task automatic doOp(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el,
                      input bit probeStall, input bit mtDuring);
    int busyCycles;
    bit stallOk;
    exp_t e;
    @(posedge clk); #1;
    multordivE = 1'b1;
    muldivopE  = op;
    srcaE      = a;
    srcbE      = b;
    if (probeStall) mfhlD = MFHL_MFLO;
    e.hi  = eh;
    e.lo  = el;
    e.cyc = cyc + 1 + WIDTH + 1;
    sb.push_back(e);
    #1;
    if (probeStall) check("stall_at_start", stallD, 1);
    @(posedge clk); #1;
    multordivE = 1'b0;
    srcaE      = ~a;
    srcbE      = b + 32'd1;
    busyCycles = 0;
    stallOk    = 1'b1;
    for (int i = 0; i < 40 && busy; i++) begin
      busyCycles++;
      if (stallD !== probeStall) stallOk = 1'b0;
      if (mtDuring) begin
        mthlW = (i == 5) ? MTHL_MTHI : MTHL_NONE;
        wdW   = 32'hDEADBEEF;
      end
      @(posedge clk); #1;
    end
    mthlW = MTHL_NONE;
    check("busy_cycles", busyCycles, WIDTH + 1);
    check("stall_during_run", stallOk, 1);
    check("stall_after_commit", stallD, 0);
    mfhlD = MFHL_NONE;
  endtask

  initial begin
    reset      = 1'b0;
    multordivE = 1'b0;
    flushE     = 1'b0;
    muldivopE  = 2'b00;
    srcaE      = '0;
    srcbE      = '0;
    mfhlD      = MFHL_NONE;
    muldivD    = 1'b0;
    mthlW      = MTHL_NONE;
    wdW        = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_stall", stallD, 0);
    reset = 1'b1;

    doOp(MD_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);
    doOp(MD_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 1'b1);
    doOp(MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    doOp(MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);
    doOp(MD_DIV,   32'h0000002A, 32'd0,        32'h0000002A, 32'hFFFFFFFF, 1'b0, 1'b0);
    doOp(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
    doOp(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
    doOp(MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
    doOp(MD_MULT,  32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b1, 1'b0);

    // Abort an operation mid-run with reset.
    @(posedge clk); #1;
    multordivE = 1'b1;
    muldivopE  = MD_MULTU;
    srcaE      = 32'h00001234;
    srcbE      = 32'h00005678;
    @(posedge clk); #1;
    multordivE = 1'b0;
    check("abort_busy_before", busy, 1);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    doOp(MD_MULTU, 32'd7, 32'd6, 32'h00000000, 32'h0000002A, 1'b0, 1'b0);

    // Flushed start is ignored.
    @(posedge clk); #1;
    multordivE = 1'b1;
    flushE     = 1'b1;
    muldivopE  = MD_MULT;
    srcaE      = 32'd5;
    srcbE      = 32'd5;
    muldivD    = 1'b1;
    #1;
    check("flush_no_stall", stallD, 0);
    @(posedge clk); #1;
    multordivE = 1'b0;
    flushE     = 1'b0;
    muldivD    = 1'b0;
    check("flush_busy", busy, 0);
    @(posedge clk); #1;
    check("flush_busy_later", busy, 0);
    check("flush_lo_kept", lo, 32'h0000002A);

    mthlW = MTHL_MTLO;
    wdW   = 32'h12345678;
    @(posedge clk); #1;
    mthlW = MTHL_NONE;
    check("mtlo_lo", lo, 32'h12345678);
    check("mtlo_hi_kept", hi, 0);
    mthlW = MTHL_MTHI;
    wdW   = 32'hCAFEF00D;
    @(posedge clk); #1;
    mthlW = MTHL_NONE;
    check("mthi_hi", hi, 32'hCAFEF00D);
    check("mthi_lo_kept", lo, 32'h12345678);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
